// File: rtl/counter_run_sequencer.sv
// Run sequencer for the counter/done model: takes a stop value, holds the counter
// in reset, releases it, times the run and reports cycle count plus status.
module counter_run_sequencer #(
    parameter int INPUT_WIDTH = 32,
    parameter int RST_CYCLES  = 2,
    parameter int TIMEOUT     = 1000,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [INPUT_WIDTH-1:0] cmd_stop_i,
    input  logic                   abort_i,
    output logic                   ctr_reset_l_o,
    output logic [INPUT_WIDTH-1:0] ctr_stop_o,
    input  logic                   ctr_done_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [CNT_WIDTH-1:0]   res_cycles_o,
    output logic [1:0]             res_status_o,
    output logic [15:0]            runs_done_o
);

    // state  | meaning
    // IDLE   | waiting for a run command, counter held in reset
    // RESET  | counter held in reset RST_CYCLES cycles with the new stop value
    // RUN    | counter released, run_cnt_q counts cycles until done/abort/timeout
    // REPORT | result presented until the consumer takes it
    typedef enum logic [1:0] {IDLE, RESET, RUN, REPORT} state_t;

    localparam logic [7:0]           RST_LAST  = 8'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    state_t                 state_q;
    logic [7:0]             rst_cnt_q;
    logic [CNT_WIDTH-1:0]   run_cnt_q;
    logic                   ctr_reset_l_q;
    logic [INPUT_WIDTH-1:0] ctr_stop_q;
    logic                   res_valid_q;
    logic [CNT_WIDTH-1:0]   res_cycles_q;
    logic [1:0]             res_status_q;
    logic [15:0]            runs_done_q;

    logic                   exit_d;
    logic [1:0]             status_d;

    // Exit priority within a RUN cycle: done, then abort, then timeout.
    always_comb begin
        exit_d   = ctr_done_i || abort_i || (run_cnt_q == TIMEOUT_C);
        status_d = 2'd1;
        if (ctr_done_i) begin
            status_d = 2'd0;
        end else if (abort_i) begin
            status_d = 2'd2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            run_cnt_q     <= '0;
            ctr_reset_l_q <= 1'b0;
            ctr_stop_q    <= '0;
            res_valid_q   <= 1'b0;
            res_cycles_q  <= '0;
            res_status_q  <= 2'd0;
            runs_done_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ctr_reset_l_q <= 1'b0;
                    if (cmd_valid_i) begin
                        ctr_stop_q <= cmd_stop_i;
                        rst_cnt_q  <= '0;
                        state_q    <= RESET;
                    end
                end
                RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        ctr_reset_l_q <= 1'b1;
                        run_cnt_q     <= '0;
                        state_q       <= RUN;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 8'd1;
                    end
                end
                RUN: begin
                    if (exit_d) begin
                        // On timeout run_cnt_q already equals TIMEOUT.
                        res_cycles_q  <= run_cnt_q;
                        res_status_q  <= status_d;
                        res_valid_q   <= 1'b1;
                        ctr_reset_l_q <= 1'b0;
                        state_q       <= REPORT;
                    end else begin
                        run_cnt_q <= run_cnt_q + CNT_WIDTH'(1);
                    end
                end
                REPORT: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        runs_done_q <= runs_done_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign ctr_reset_l_o = ctr_reset_l_q;
    assign ctr_stop_o    = ctr_stop_q;
    assign res_valid_o   = res_valid_q;
    assign res_cycles_o  = res_cycles_q;
    assign res_status_o  = res_status_q;
    assign runs_done_o   = runs_done_q;

endmodule

// File: tb/tb_counter_run_sequencer.sv
// Self-checking bench for counter_run_sequencer with a behavioural counter model
// and an arithmetic reference for the expected cycle count and status.
module tb_counter_run_sequencer;

    localparam int          RST   = 2;
    localparam int          TMO   = 100;
    localparam logic [31:0] START = 32'd10;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_stop;
    logic        abort;
    logic        ctr_reset_l;
    logic [31:0] ctr_stop;
    logic        ctr_done;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_cycles;
    logic [1:0]  res_status;
    logic [15:0] runs_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_runs = 16'd0;

    counter_run_sequencer #(
        .INPUT_WIDTH(32), .RST_CYCLES(RST), .TIMEOUT(TMO), .CNT_WIDTH(32)
    ) dut (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_stop_i(cmd_stop), .abort_i(abort), .ctr_reset_l_o(ctr_reset_l),
        .ctr_stop_o(ctr_stop), .ctr_done_i(ctr_done), .res_valid_o(res_valid),
        .res_ready_i(res_ready), .res_cycles_o(res_cycles), .res_status_o(res_status),
        .runs_done_o(runs_done)
    );

    always #5 clk = ~clk;

    // Counter model: loads START in reset, counts up otherwise; done is garbage in reset.
    logic [31:0] cnt_q;
    logic        junk_q;
    always_ff @(posedge clk) begin
        cnt_q  <= (ctr_reset_l === 1'b1) ? cnt_q + 32'd1 : START;
        junk_q <= 1'($urandom);
    end
    assign ctr_done = (ctr_reset_l === 1'b1) ? (cnt_q == ctr_stop) : junk_q;

    // Reference outcome: earliest of done (k), abort and timeout; ties go done > abort > timeout.
    function automatic void ref_model(input logic [31:0] stop, input int abort_at,
                                      output int cyc, output int st);
        logic [31:0] k;
        k   = stop - START;
        cyc = TMO;
        st  = 1;
        if (abort_at >= 0 && abort_at <= cyc) begin
            cyc = abort_at;
            st  = 2;
        end
        if (k <= 32'(cyc)) begin
            cyc = int'(k);
            st  = 0;
        end
    endfunction

    task automatic run_one(input logic [31:0] stop, input int abort_at,
                           input int ready_delay, input bit abort_in_reset);
        int exp_cyc, exp_st, low, high;
        bit got, stop_bad;
        ref_model(stop, abort_at, exp_cyc, exp_st);
        low = 0; high = 0; got = 0; stop_bad = 0;
        for (int c = 0; c < 20 && cmd_ready !== 1'b1; c++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_stop  = stop;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < TMO + 50; c++) begin
            if (res_valid === 1'b1) begin
                got = 1;
                break;
            end
            if (ctr_reset_l === 1'b1) begin
                abort = (high == abort_at);
                high++;
            end else begin
                abort = abort_in_reset;
                low++;
            end
            if (ctr_stop !== stop) stop_bad = 1;
            @(negedge clk);
        end
        abort = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL result_seen: res_valid never rose for stop=%0d", stop);
        end
        n_checks++;
        if (low !== RST) begin
            n_fail++;
            $display("FAIL reset_low_cycles: got %0d expected %0d", low, RST);
        end
        n_checks++;
        if (high !== exp_cyc + 1) begin
            n_fail++;
            $display("FAIL reset_high_cycles: got %0d expected %0d", high, exp_cyc + 1);
        end
        n_checks++;
        if (stop_bad) begin
            n_fail++;
            $display("FAIL ctr_stop_stable: ctr_stop left %0d during run", stop);
        end
        n_checks++;
        if (res_cycles !== 32'(exp_cyc) || res_status !== 2'(exp_st)) begin
            n_fail++;
            $display("FAIL result: got cycles %0d status %0d expected cycles %0d status %0d",
                     res_cycles, res_status, exp_cyc, exp_st);
        end
        n_checks++;
        if (ctr_reset_l !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL report_outputs: got reset_l %b cmd_ready %b expected 0 0",
                     ctr_reset_l, cmd_ready);
        end
        for (int d = 0; d < ready_delay; d++) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b1 || res_cycles !== 32'(exp_cyc) || cmd_ready !== 1'b0
                || runs_done !== exp_runs) begin
                n_fail++;
                $display("FAIL report_hold: got valid %b cycles %0d ready %b runs %0d expected 1 %0d 0 %0d",
                         res_valid, res_cycles, cmd_ready, runs_done, exp_cyc, exp_runs);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_runs  = exp_runs + 16'd1;
        n_checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || runs_done !== exp_runs) begin
            n_fail++;
            $display("FAIL report_handshake: got valid %b ready %b runs %0d expected 0 1 %0d",
                     res_valid, cmd_ready, runs_done, exp_runs);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd_stop = 32'd77; abort = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || ctr_reset_l !== 1'b0 || ctr_stop !== 32'd0 || res_valid !== 1'b0
            || res_cycles !== 32'd0 || res_status !== 2'd0 || runs_done !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got ready %b rl %b stop %0d valid %b cyc %0d st %0d runs %0d expected 1 0 0 0 0 0 0",
                     cmd_ready, ctr_reset_l, ctr_stop, res_valid, res_cycles, res_status, runs_done);
        end
        cmd_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_one(START + 32'd5, -1, 0, 0);
        run_one(START, -1, 0, 0);
    endtask

    task automatic test_timeout();
        run_one(32'd5, -1, 0, 0);
        run_one(START + 32'(TMO), -1, 0, 0);
        run_one(START + 32'(TMO) + 32'd1, -1, 1, 0);
    endtask

    task automatic test_abort();
        run_one(32'd1000, 7, 0, 1);
        run_one(32'd1000, 0, 0, 0);
        run_one(START + 32'd20, 20, 0, 0);
        run_one(32'd1000, TMO, 0, 1);
    endtask

    task automatic test_report_stall();
        run_one(START + 32'd5, -1, 3, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [31:0] stop;
            int ab;
            case ($urandom_range(0, 3))
                0:       stop = START + 32'($urandom_range(0, 15));
                1:       stop = START + 32'($urandom_range(TMO - 5, TMO + 5));
                2:       stop = $urandom;
                default: stop = START + 32'($urandom_range(0, 60));
            endcase
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO + 10)) : -1;
            run_one(stop, ab, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        int hs[$];
        int n_res;
        n_res     = 0;
        res_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_stop  = START + 32'd3;
        for (int c = 0; c < 100; c++) begin
            if (res_valid === 1'b1) begin
                n_res++;
                n_checks++;
                if (res_cycles !== 32'd3 || res_status !== 2'd0) begin
                    n_fail++;
                    $display("FAIL b2b_result: got cycles %0d status %0d expected 3 0",
                             res_cycles, res_status);
                end
            end
            if (cmd_ready === 1'b1) begin
                if (hs.size() == 3) begin
                    cmd_valid = 1'b0;
                    break;
                end
                hs.push_back(c);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        n_checks++;
        if (hs.size() !== 3 || n_res !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d handshakes %0d results expected 3 3", hs.size(), n_res);
        end
        for (int i = 0; i + 1 < hs.size(); i++) begin
            n_checks++;
            if (hs[i+1] - hs[i] !== RST + 3 + 3) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d expected %0d", hs[i+1] - hs[i], RST + 6);
            end
        end
        exp_runs = exp_runs + 16'd3;
        @(negedge clk);
        n_checks++;
        if (runs_done !== exp_runs) begin
            n_fail++;
            $display("FAIL b2b_runs_done: got %0d expected %0d", runs_done, exp_runs);
        end
    endtask

    task automatic test_reset_mid_run();
        int high;
        high = 0;
        cmd_valid = 1'b1;
        cmd_stop  = START + 32'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ctr_reset_l === 1'b1) begin
                if (high == 4) break;
                high++;
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        exp_runs = 16'd0;
        n_checks++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || runs_done !== 16'd0 || ctr_reset_l !== 1'b0
            || ctr_stop !== 32'd0 || res_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_run_reset: got ready %b valid %b runs %0d rl %b stop %0d cyc %0d expected 1 0 0 0 0 0",
                     cmd_ready, res_valid, runs_done, ctr_reset_l, ctr_stop, res_cycles);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_idle: got valid %b ready %b expected 0 1", res_valid, cmd_ready);
        end
        run_one(START + 32'd2, -1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_abort();
        test_report_stall();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
